// File: rtl/cmp_scan_sched_pkg.sv
// Shared definitions for the comparator scan scheduler: FSM encoding and
// the persistence-counter width helper.
package cmp_scan_sched_pkg;

    localparam int DEF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic int cnt_w(input int hold);
        return $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/cmp_scan_sched_persist_filter.sv
// Per-channel persistence filter: counts consecutive over-threshold samples,
// saturating at HOLD, and raises the alarm once the count reaches HOLD.
module persist_filter
    import cmp_scan_sched_pkg::*;
#(
    parameter int HOLD = 3,
    localparam int CW = cnt_w(HOLD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          upd,
    input  logic          gt,
    output logic [CW-1:0] cnt,
    output logic          alarm
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          alarm_q;

    // Saturating increment so the counter never wraps past HOLD.
    assign cnt_d = (cnt_q == CW'(HOLD)) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q   <= '0;
            alarm_q <= 1'b0;
        end else if (upd) begin
            if (gt) begin
                cnt_q   <= cnt_d;
                alarm_q <= (cnt_d == CW'(HOLD));
            end else begin
                cnt_q   <= '0;
                alarm_q <= 1'b0;
            end
        end
    end

    assign cnt   = cnt_q;
    assign alarm = alarm_q;

endmodule

// File: rtl/cmp_scan_sched.sv
// Time-multiplexes one external greater-than comparator over NCH channels and
// debounces each channel's result into an alarm flag.
module cmp_scan_sched
    import cmp_scan_sched_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int W    = DEF_W,
    parameter int HOLD = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic [NCH-1:0]   ch_en,
    input  logic [NCH*W-1:0] ch_val,
    input  logic [NCH*W-1:0] ch_thr,
    output logic [W-1:0]     cmp_a,
    output logic [W-1:0]     cmp_b,
    input  logic             cmp_gt,
    output logic             busy,
    output logic [NCH-1:0]   alarm,
    output logic             scan_done
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = cnt_w(HOLD);

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [NCH-1:0]  mask_q;
    logic [W-1:0]    cmp_a_q;
    logic [W-1:0]    cmp_b_q;
    logic            busy_q;
    logic            done_q;

    logic            latch_d;
    logic [IW:0]     first_d;
    logic [IW:0]     next_d;
    logic [NCH-1:0]  clr_d;
    logic [NCH-1:0]  upd_d;
    logic [CW-1:0]   cnt_unused [NCH];

    // Lowest set bit of m at or above lo; MSB of the result flags a hit.
    function automatic logic [IW:0] next_set(input logic [NCH-1:0] m, input int lo);
        logic [IW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (i >= lo)) begin
                r = {1'b1, IW'(i)};
            end
        end
        return r;
    endfunction

    assign latch_d = ((state_q == ST_IDLE) && start) || ((state_q == ST_DONE) && cont);
    assign first_d = next_set(ch_en, 0);
    assign next_d  = next_set(mask_q, int'(idx_q) + 1);
    assign clr_d   = latch_d ? ~ch_en : '0;
    assign upd_d   = (state_q == ST_SAMPLE) ? (NCH'(1) << idx_q) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            cmp_a_q <= '0;
            cmp_b_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (latch_d) begin
                mask_q <= ch_en;
                busy_q <= 1'b1;
                if (first_d[IW]) begin
                    state_q <= ST_DRIVE;
                    idx_q   <= first_d[IW-1:0];
                end else begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_DRIVE: begin
                        cmp_a_q <= ch_val[idx_q*W +: W];
                        cmp_b_q <= ch_thr[idx_q*W +: W];
                        state_q <= ST_SAMPLE;
                    end
                    ST_SAMPLE: begin
                        if (next_d[IW]) begin
                            state_q <= ST_DRIVE;
                            idx_q   <= next_d[IW-1:0];
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            persist_filter #(.HOLD(HOLD)) u_pf (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr_d[gi]),
                .upd   (upd_d[gi]),
                .gt    (cmp_gt),
                .cnt   (cnt_unused[gi]),
                .alarm (alarm[gi])
            );
        end
    endgenerate

    assign cmp_a     = cmp_a_q;
    assign cmp_b     = cmp_b_q;
    assign busy      = busy_q;
    assign scan_done = done_q;

endmodule

// File: doc/cmp_scan_sched.md
Name: cmp_scan_sched

Overview:
Time-multiplexed scheduler that shares one external 16-bit greater-than comparator (result = in > ref, 0 while rst) among NCH monitored channels. On each scan it visits every enabled channel in ascending index order. It drives the channel's value/threshold onto the shared comparator and samples the result. A per-channel persistence filter turns the results into debounced alarm flags. It sits between the acquisition registers and the alarm/status logic.

Parameters:
NCH, 4, number of channels (2..16)
W, 16, data/threshold width
HOLD, 3, consecutive over-threshold samples needed to raise an alarm (1..15)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a scan; sampled only in IDLE
cont  in  1  1 = rescan immediately after each scan; sampled in DONE
ch_en  in  NCH  channel enable mask; latched on scan start
ch_val  in  NCH*W  channel values, channel i at [i*W +: W]
ch_thr  in  NCH*W  channel thresholds, same packing
cmp_a  out  W  registered operand to comparator "in"
cmp_b  out  W  registered operand to comparator "ref"
cmp_gt  in  1  comparator result for the operands currently on cmp_a/cmp_b
busy  out  1  high in every state except IDLE
alarm  out  NCH  debounced over-threshold flags
scan_done  out  1  one-cycle pulse at the end of each scan

Behaviour:
- Reset (synchronous): state=IDLE; cmp_a, cmp_b, busy, alarm, scan_done, the latched mask, the channel index and all persistence counters go to 0. Reset asserted mid-scan aborts the scan with no scan_done pulse.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: if start=1, latch ch_en into the mask. If mask≠0, go to DRIVE with idx = lowest set bit; else go to DONE.
- DRIVE (1 cycle): register cmp_a=ch_val[idx], cmp_b=ch_thr[idx]; go to SAMPLE.
- SAMPLE (1 cycle): cmp_gt is valid (comparator is combinational on the registered operands).
  - If cmp_gt=1: cnt[idx] = min(cnt[idx]+1, HOLD); alarm[idx] sets when the new cnt = HOLD.
  - If cmp_gt=0: cnt[idx]=0 and alarm[idx]=0 in the same update.
  - Next state: DRIVE with the next higher set mask bit, or DONE if none remains. Disabled channels cost zero cycles.
- DONE (1 cycle): scan_done=1. If cont=1, re-latch ch_en and proceed exactly as IDLE with start=1; else go to IDLE.
- Latency: a scan with k enabled channels takes 2k+1 cycles from the first state after IDLE through DONE inclusive. Alarm changes are visible the cycle after the corresponding SAMPLE.
- Channels not in the latched mask: cnt and alarm are cleared when the mask is latched, and stay 0 for that scan.
- start while busy is ignored. Changing ch_en mid-scan has no effect until the next latch. ch_val/ch_thr are read live in DRIVE only.
- Comparison is unsigned, strict greater-than. Equal values count as not-over.
- Counter width is $clog2(HOLD+1). Saturates at HOLD; never wraps.
- cmp_a/cmp_b hold their last value outside DRIVE.

Decomposition:
- Shared package: FSM state encoding (2-bit enum IDLE/DRIVE/SAMPLE/DONE), CNT_W function/constant, and a default-width constant of 16.
- One natural sub-module: persist_filter (per channel): inputs clk, rst, clr, upd, gt; outputs cnt, alarm; instantiated NCH times by generate.
- The priority "next set bit above idx" finder stays as a function inside the scheduler.

Test Plan:
1. rst=1 for 2 cycles mid-scan (during SAMPLE of ch1) -> next cycle state IDLE, busy=0, alarm=0, no scan_done pulse.
2. NCH=4, ch_en=4'b1111, all ch_val=100, ch_thr=50, start pulse at cycle 0 -> scan_done at cycle 9. After 3 single-shot scans alarm=4'b1111; after 2 scans alarm=4'b0000.
3. ch_en=4'b1010 -> only ch1 and ch3 appear on cmp_a; scan_done 5 cycles after leaving IDLE; alarm[0] and alarm[2] stay 0.
4. ch0 val=50, thr=50 (equal) -> alarm[0] never sets. Then val=51 for 3 scans -> alarm[0]=1. Then val=49 for 1 scan -> alarm[0]=0 the cycle after SAMPLE.
5. cont=1, ch_en=4'b0001 -> DONE followed directly by DRIVE, scan_done every 3 cycles. Dropping cont -> IDLE after the current DONE.
6. ch_en=0 with start -> DONE next cycle, scan_done=1 for one cycle, alarm=0; start held high during a scan -> no extra or restarted scan.
